// File: rtl/fib_req_arb.sv
// Round-robin arbiter feeding parse-to-FIB requests into a one-entry output slot.
// Lookups are credit-limited, and a credit is returned on each lkup_done_i pulse.

`ifndef PAR_DATA_SZ
`define PAR_DATA_SZ 32
`endif

module fib_req_arb #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned DATA_SZ   = `PAR_DATA_SZ,
   parameter int unsigned CREDITS   = 4,
   localparam int unsigned PW       = $clog2(NUM_PORTS),
   localparam int unsigned CW       = $clog2(CREDITS + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_PORTS-1:0]         p2f_srdy_i,
   input  logic [NUM_PORTS*DATA_SZ-1:0] p2f_data_i,
   output logic [NUM_PORTS-1:0]         p2f_drdy_o,
   output logic                         lkup_srdy_o,
   input  logic                         lkup_drdy_i,
   output logic [DATA_SZ-1:0]           lkup_data_o,
   output logic [PW-1:0]                lkup_port_o,
   input  logic                         lkup_done_i,
   output logic [CW-1:0]                credit_cnt_o,
   output logic                         err_oflow_o
);

   logic               lkup_srdy_q;
   logic [DATA_SZ-1:0] lkup_data_q;
   logic [PW-1:0]      lkup_port_q;
   logic [PW-1:0]      rr_ptr_q;
   logic [CW-1:0]      credit_q;
   logic               err_oflow_q;

   logic               slot_free;
   logic               found;
   logic               grant;
   logic [PW-1:0]      winner;
   logic [PW-1:0]      rr_next;
   logic [DATA_SZ-1:0] win_data;

   assign slot_free = !lkup_srdy_q || lkup_drdy_i;

   // Scan from the highest offset down so the port closest to rr_ptr wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (p2f_srdy_i[PW'((int'(rr_ptr_q) + k) % int'(NUM_PORTS))]) begin
            found  = 1'b1;
            winner = PW'((int'(rr_ptr_q) + k) % int'(NUM_PORTS));
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (winner == PW'(i)) begin
            win_data = p2f_data_i[i*DATA_SZ +: DATA_SZ];
         end
      end
   end

   // Eligibility looks only at the registered credit count, so a done pulse
   // arriving at zero credits enables a grant one cycle later.
   assign grant   = !reset_i && slot_free && (credit_q != '0) && found;
   assign rr_next = (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);

   always_comb begin
      p2f_drdy_o = '0;
      if (grant) begin
         p2f_drdy_o[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lkup_srdy_q <= 1'b0;
         lkup_data_q <= '0;
         lkup_port_q <= '0;
         rr_ptr_q    <= '0;
         credit_q    <= CW'(CREDITS);
         err_oflow_q <= 1'b0;
      end else begin
         if (grant) begin
            lkup_srdy_q <= 1'b1;
            lkup_data_q <= win_data;
            lkup_port_q <= winner;
            rr_ptr_q    <= rr_next;
         end else if (slot_free) begin
            lkup_srdy_q <= 1'b0;
         end

         unique case ({grant, lkup_done_i})
            2'b10: credit_q <= credit_q - CW'(1);
            2'b01: begin
               if (credit_q == CW'(CREDITS)) begin
                  err_oflow_q <= 1'b1;
               end else begin
                  credit_q <= credit_q + CW'(1);
               end
            end
            default: credit_q <= credit_q;
         endcase
      end
   end

   assign lkup_srdy_o  = lkup_srdy_q;
   assign lkup_data_o  = lkup_data_q;
   assign lkup_port_o  = lkup_port_q;
   assign credit_cnt_o = credit_q;
   assign err_oflow_o  = err_oflow_q;

endmodule
